mxv_engine: RTL and testbench

Matrix-vector multiply stage between the UART receive and transmit paths. It accepts a word stream from the UART receiver: a size word, then an N×N matrix in row-major order, then an N-element vector. It computes y = M·v one multiply-accumulate per cycle and hands each 16-bit result to the UART transmitter through a start/done handshake.

---
 rtl/mxv_if.sv | 24 ++
 rtl/mxv_engine.sv | 147 ++++++++++++++
 tb/tb_mxv_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mxv_if.sv
// UART-facing word stream for the matrix-vector engine: received words come in,
// result words go out, and every transfer is a strobe rather than a valid/ready pair.
interface mxv_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic              tx_done;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;

  // UART side: drives received words and transmitter status
  modport master (
    output rx_data, rx_valid, tx_busy, tx_done,
    input  tx_data, tx_start
  );

  // Engine side
  modport slave (
    input  rx_data, rx_valid, tx_busy, tx_done,
    output tx_data, tx_start
  );
endinterface

// File: rtl/mxv_engine.sv
// Matrix-vector multiply between UART rx and tx: loads N, M (row-major) and v,
// then streams y = M*v one MAC per cycle, one result word per transmission.
module mxv_engine #(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 8
) (
  input  logic       clk,
  input  logic       rst,
  mxv_if.slave       bus,
  output logic       busy,
  output logic       done,
  output logic       err_size,
  output logic       err_overrun,
  output logic [2:0] state_dbg
);
  localparam int NW    = $clog2(MAX_N + 1);
  localparam int IW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N);
  localparam logic [DATA_W-1:0] MAX_N_W = DATA_W'(MAX_N);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M  = 3'd1,
    LOAD_V  = 3'd2,
    MAC     = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t             state;
  logic [NW-1:0]      n, r, k;
  logic [NW-1:0]      n_last;
  logic [ACC_W-1:0]   acc, prod, acc_next;
  logic [DATA_W-1:0]  m_mem [MAX_N][MAX_N];
  logic [DATA_W-1:0]  v_mem [MAX_N];

  assign n_last    = n - NW'(1);
  assign prod      = ACC_W'(m_mem[r[IW-1:0]][k[IW-1:0]]) * ACC_W'(v_mem[k[IW-1:0]]);
  assign acc_next  = acc + prod;
  assign state_dbg = state;

  // Storage is not reset: every entry is rewritten by the load phases before use.
  always_ff @(posedge clk) begin
    if (state == LOAD_M && bus.rx_valid) m_mem[r[IW-1:0]][k[IW-1:0]] <= bus.rx_data;
    if (state == LOAD_V && bus.rx_valid) v_mem[k[IW-1:0]] <= bus.rx_data;
  end

  // Handshake: rx_valid is a one-cycle strobe with no backpressure, so a word
  // arriving outside the load states is dropped and flagged. tx_start is a
  // one-cycle request issued only while tx_busy is low; tx_done closes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      n           <= '0;
      r           <= '0;
      k           <= '0;
      acc         <= '0;
      bus.tx_data <= '0;
      bus.tx_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_size    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      done         <= 1'b0;
      err_size     <= 1'b0;
      err_overrun  <= 1'b0;
      if ((state == MAC || state == SEND || state == WAIT_TX) && bus.rx_valid)
        err_overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data != '0 && bus.rx_data <= MAX_N_W) begin
              n     <= bus.rx_data[NW-1:0];
              r     <= '0;
              k     <= '0;
              busy  <= 1'b1;
              state <= LOAD_M;
            end else begin
              err_size <= 1'b1;
            end
          end
        end
        LOAD_M: begin
          if (bus.rx_valid) begin
            if (k == n_last) begin
              k <= '0;
              if (r == n_last) begin
                r     <= '0;
                state <= LOAD_V;
              end else begin
                r <= r + NW'(1);
              end
            end else begin
              k <= k + NW'(1);
            end
          end
        end
        LOAD_V: begin
          if (bus.rx_valid) begin
            if (k == n_last) begin
              k     <= '0;
              acc   <= '0;
              state <= MAC;
            end else begin
              k <= k + NW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + NW'(1);
          if (k == n_last) begin
            // Look ahead at tx_busy so an idle transmitter is requested on SEND entry.
            bus.tx_data  <= acc_next[DATA_W-1:0];
            bus.tx_start <= !bus.tx_busy;
            state        <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_start) begin
            state <= WAIT_TX;
          end else if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            state        <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (bus.tx_done) begin
            if (r == n_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              r     <= r + NW'(1);
              k     <= '0;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mxv_engine.sv
// Directed bench for mxv_engine: hand-computed result streams, size errors,
// transmitter backpressure, overrun words and mid-load reset.
module tb_mxv_engine;
  localparam int DATA_W = 16;
  localparam int MAX_N  = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_MAC = 3'd3, S_SEND = 3'd4, S_WAIT_TX = 3'd5;

  logic       clk;
  logic       rst;
  logic       busy, done, err_size, err_overrun;
  logic [2:0] state_dbg;

  mxv_if #(.DATA_W(DATA_W)) bus ();

  mxv_engine #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .err_size    (err_size),
    .err_overrun (err_overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0, done_cnt = 0, ovr_cnt = 0;
  int tx_cd = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] stim_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // transmitter model and event monitor: tx_done two cycles after tx_start
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_done) bus.tx_done = 1'b0;
      if (tx_cd > 0) begin
        tx_cd--;
        if (tx_cd == 0) bus.tx_done = 1'b1;
      end
      if (bus.tx_start) begin
        got_q.push_back(bus.tx_data);
        start_cnt++;
        tx_cd = 2;
      end
      if (done) done_cnt++;
      if (err_overrun) ovr_cnt++;
    end
  end

  // driver tasks
  task automatic put(input logic [DATA_W-1:0] w);
    @(negedge clk);
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle_rx();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_all();
    foreach (stim_q[i]) put(stim_q[i]);
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    stim_q.delete();
    start_cnt = 0;
    done_cnt  = 0;
    ovr_cnt   = 0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state_dbg == s) break;
      @(negedge clk);
    end
    check(tag, {29'd0, state_dbg}, {29'd0, s});
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= 1) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check(tag, done_cnt, 1);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // scoreboard compare of transmitted words against expected queue
  task automatic check_results(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    check({tag, "_starts"}, start_cnt, exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s_y%0d", tag, i),
            (i < got_q.size()) ? {16'd0, got_q[i]} : 32'hxxxx_xxxx, {16'd0, exp_q[i]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_data"}, {16'd0, bus.tx_data}, 0);
    check({tag, "_outs"}, {27'd0, bus.tx_start, busy, done, err_size, err_overrun}, 0);
    check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, S_IDLE});
  endtask

  task automatic load_n2_basic();
    stim_q = '{16'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    exp_q  = '{16'd17, 16'd39};
  endtask

  initial begin
    rst          = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // N=2 basic run with latency check
    clear_sb();
    load_n2_basic();
    send_all();
    idle_rx();
    @(negedge clk);
    check("t1_mac_state", {29'd0, state_dbg}, {29'd0, S_MAC});
    check("t1_no_start_yet", {31'd0, bus.tx_start}, 0);
    @(negedge clk);
    check("t1_send_state", {29'd0, state_dbg}, {29'd0, S_SEND});
    check("t1_start", {31'd0, bus.tx_start}, 1);
    check("t1_tx_data", {16'd0, bus.tx_data}, 17);
    wait_done("t1_done", 200);
    check_results("t1");
    check("t1_no_ovr", ovr_cnt, 0);

    // size errors then size 1
    clear_sb();
    put(16'd0);
    idle_rx();
    check("t2_err_size0", {31'd0, err_size}, 1);
    check("t2_idle0", {29'd0, state_dbg}, {29'd0, S_IDLE});
    put(16'(MAX_N + 1));
    idle_rx();
    check("t2_err_size9", {31'd0, err_size}, 1);
    check("t2_busy", {31'd0, busy}, 0);
    @(negedge clk);
    check("t2_err_clear", {31'd0, err_size}, 0);
    stim_q = '{16'd1, 16'd7, 16'd3};
    exp_q  = '{16'd21};
    send_all();
    idle_rx();
    wait_done("t2_done", 200);
    check_results("t2");

    // N=1 low-word wrap: 0xFFFF*0xFFFF = 0xFFFE0001
    clear_sb();
    stim_q = '{16'd1, 16'hFFFF, 16'hFFFF};
    exp_q  = '{16'h0001};
    send_all();
    idle_rx();
    wait_done("t3_done", 200);
    check_results("t3");

    // N=3 with transmitter busy on first result
    clear_sb();
    stim_q = '{16'd3, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9,
               16'd1, 16'd1, 16'd2};
    exp_q  = '{16'd9, 16'd21, 16'd33};
    bus.tx_busy = 1'b1;
    send_all();
    idle_rx();
    wait_state("t4_reach_send", S_SEND, 200);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_hold_start%0d", i), {31'd0, bus.tx_start}, 0);
      check($sformatf("t4_hold_data%0d", i), {16'd0, bus.tx_data}, 9);
      @(negedge clk);
    end
    bus.tx_busy = 1'b0;
    check("t4_still_low", {31'd0, bus.tx_start}, 0);
    @(negedge clk);
    check("t4_start", {31'd0, bus.tx_start}, 1);
    check("t4_data", {16'd0, bus.tx_data}, 9);
    wait_done("t4_done", 300);
    check_results("t4");

    // overrun words during MAC and WAIT_TX are dropped
    clear_sb();
    load_n2_basic();
    send_all();
    put(16'hAAAA);
    idle_rx();
    check("t5_ovr_mac", {31'd0, err_overrun}, 1);
    wait_state("t5_reach_wait", S_WAIT_TX, 200);
    put(16'hAAAA);
    idle_rx();
    check("t5_ovr_wait", {31'd0, err_overrun}, 1);
    wait_done("t5_done", 200);
    check_results("t5");
    check("t5_ovr_cnt", ovr_cnt, 2);

    // reset after 3 of 4 matrix words, then a fresh stream
    clear_sb();
    stim_q = '{16'd2, 16'd1, 16'd2, 16'd3};
    send_all();
    idle_rx();
    check("t6_busy_before", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    check_all_zero("t6_reset");
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    load_n2_basic();
    send_all();
    idle_rx();
    wait_done("t6_done", 200);
    check_results("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
